// File: rtl/generate_6_bit_sequence_using_fsm_pkg.sv
// Shared types and helpers for the serial pattern generator.
// The optional parity bit is controlled by the macro SEQ_GEN_PARITY_EN.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } seq_gen_state_t;

   localparam logic [5:0] DEFAULT_PATTERN = 6'b110011;

   // Zero padding above the pattern leaves the XOR unchanged.
   function automatic logic even_parity(input logic [15:0] value);
      return ^value;
   endfunction

endpackage

// File: rtl/generate_6_bit_sequence_using_fsm_if.sv
// Request/serial-output bundle of the pattern generator.
// The generator is the slave; whoever requests frames is the master.
interface generate_6_bit_sequence_using_fsm_if #(
   parameter int PATTERN_W   = 6,
   parameter int FRAME_CNT_W = 4
) ();

   logic                   start;
   logic [PATTERN_W-1:0]   pattern;
   logic [FRAME_CNT_W-1:0] frames;
   logic                   abort;
   logic                   ready;
   logic                   a;
   logic                   a_valid;
   logic                   done;

   modport master (
      output start, pattern, frames, abort,
      input  ready, a, a_valid, done
   );

   modport slave (
      input  start, pattern, frames, abort,
      output ready, a, a_valid, done
   );

endinterface

// File: rtl/generate_6_bit_sequence_using_fsm_shifter.sv
// Loadable MSB-first shift register with bit counter.
// SEQ_GEN_PARITY_EN appends an even-parity slot after the pattern bits.
module seq_gen_shifter
   import seq_gen_pkg::*;
#(
   parameter int PATTERN_W = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 reload,
   input  logic                 shift,
   input  logic [PATTERN_W-1:0] din,
   output logic                 bit_out,
   output logic                 last_bit
);

   localparam int CNT_W = $clog2(PATTERN_W + 1);
`ifdef SEQ_GEN_PARITY_EN
   localparam int LAST_IDX = PATTERN_W;
`else
   localparam int LAST_IDX = PATTERN_W - 1;
`endif

   logic [PATTERN_W-1:0] pat_r;
   logic [PATTERN_W-1:0] sh_r;
   logic [CNT_W-1:0]     cnt_r;

   // Pattern copy is kept so later frames can reload without the input port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_r <= {PATTERN_W{1'b0}};
         sh_r  <= {PATTERN_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
      end else if (load) begin
         pat_r <= din;
         sh_r  <= din;
         cnt_r <= {CNT_W{1'b0}};
      end else if (reload) begin
         sh_r  <= pat_r;
         cnt_r <= {CNT_W{1'b0}};
      end else if (shift) begin
         sh_r  <= {sh_r[PATTERN_W-2:0], 1'b0};
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         sh_r  <= sh_r;
         cnt_r <= cnt_r;
      end
   end

   // Current serial bit and end-of-frame flag.
   always_comb begin
      bit_out  = sh_r[PATTERN_W-1];
      last_bit = (cnt_r == CNT_W'(LAST_IDX));
`ifdef SEQ_GEN_PARITY_EN
      if (cnt_r == CNT_W'(PATTERN_W)) begin
         bit_out = even_parity(16'(pat_r));
      end else begin
         bit_out = sh_r[PATTERN_W-1];
      end
`endif
   end

endmodule

// File: rtl/generate_6_bit_sequence_using_fsm.sv
// Serializes a pattern MSB first for a requested number of frames with optional idle gaps.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to every frame.
module generate_6_bit_sequence_using_fsm
   import seq_gen_pkg::*;
#(
   parameter int PATTERN_W   = 6,
   parameter int GAP_CYCLES  = 2,
   parameter int FRAME_CNT_W = 4
) (
   input  logic clk,
   input  logic rst_n,
   generate_6_bit_sequence_using_fsm_if.slave bus
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : {GAP_W{1'b0}};

   seq_gen_state_t         state_r, state_next;
   logic [FRAME_CNT_W-1:0] frame_cnt_r, frame_cnt_next;
   logic [GAP_W-1:0]       gap_cnt_r, gap_cnt_next;
   logic                   load_s, reload_s, shift_s;
   logic                   bit_s, last_bit_s;
   logic                   ready_r, a_r, a_valid_r, done_r;
   logic                   ready_next, a_next, a_valid_next, done_next;

   seq_gen_shifter #(.PATTERN_W(PATTERN_W)) u_shifter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_s),
      .reload   (reload_s),
      .shift    (shift_s),
      .din      (bus.pattern),
      .bit_out  (bit_s),
      .last_bit (last_bit_s)
   );

   // Next state and counter updates; abort overrides every transition.
   always_comb begin
      state_next     = state_r;
      frame_cnt_next = frame_cnt_r;
      gap_cnt_next   = gap_cnt_r;
      load_s         = 1'b0;
      reload_s       = 1'b0;
      shift_s        = 1'b0;
      if (bus.abort) begin
         state_next = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (ready_r && bus.start && (bus.frames != {FRAME_CNT_W{1'b0}})) begin
                  load_s         = 1'b1;
                  frame_cnt_next = bus.frames;
                  state_next     = SEND;
               end else begin
                  state_next = IDLE;
               end
            end
            SEND: begin
               shift_s = 1'b1;
               if (!last_bit_s) begin
                  state_next = SEND;
               end else if (frame_cnt_r == FRAME_CNT_W'(1)) begin
                  state_next = DONE;
               end else begin
                  frame_cnt_next = frame_cnt_r - FRAME_CNT_W'(1);
                  if (GAP_CYCLES > 0) begin
                     gap_cnt_next = {GAP_W{1'b0}};
                     state_next   = GAP;
                  end else begin
                     reload_s   = 1'b1;
                     state_next = SEND;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_r == GAP_LAST) begin
                  reload_s   = 1'b1;
                  state_next = SEND;
               end else begin
                  gap_cnt_next = gap_cnt_r + GAP_W'(1);
               end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Output values for the next cycle; ready stays low for the cycle leaving DONE.
   always_comb begin
      ready_next = (state_next == IDLE) && (state_r != DONE);
      done_next  = !bus.abort && (state_r == DONE);
      if (!bus.abort && (state_r == SEND)) begin
         a_next       = bit_s;
         a_valid_next = 1'b1;
      end else begin
         a_next       = 1'b0;
         a_valid_next = 1'b0;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         frame_cnt_r <= {FRAME_CNT_W{1'b0}};
         gap_cnt_r   <= {GAP_W{1'b0}};
         ready_r     <= 1'b1;
         a_r         <= 1'b0;
         a_valid_r   <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_next;
         frame_cnt_r <= frame_cnt_next;
         gap_cnt_r   <= gap_cnt_next;
         ready_r     <= ready_next;
         a_r         <= a_next;
         a_valid_r   <= a_valid_next;
         done_r      <= done_next;
      end
   end

   assign bus.ready   = ready_r;
   assign bus.a       = a_r;
   assign bus.a_valid = a_valid_r;
   assign bus.done    = done_r;

endmodule

// File: tb/tb_generate_6_bit_sequence_using_fsm.sv
// Directed bench: an expected {a,a_valid,done,ready} stream is queued per request and compared each cycle.
module tb_generate_6_bit_sequence_using_fsm;
   import seq_gen_pkg::*;

   logic clk;
   logic rst_n;

   generate_6_bit_sequence_using_fsm_if #(.PATTERN_W(6), .FRAME_CNT_W(4)) bus1 ();
   generate_6_bit_sequence_using_fsm_if #(.PATTERN_W(6), .FRAME_CNT_W(4)) bus2 ();

   generate_6_bit_sequence_using_fsm #(.PATTERN_W(6), .GAP_CYCLES(2), .FRAME_CNT_W(4)) dut1 (
      .clk (clk), .rst_n (rst_n), .bus (bus1)
   );
   generate_6_bit_sequence_using_fsm #(.PATTERN_W(6), .GAP_CYCLES(0), .FRAME_CNT_W(4)) dut2 (
      .clk (clk), .rst_n (rst_n), .bus (bus2)
   );

   logic [3:0] q1[$];
   logic [3:0] q2[$];
   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   string cur_tag;

   logic       det_clr;
   logic [5:0] det_sh;
   int         det_len;
   int         det_hits;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference 110011 detector on the gap-less generator's valid bits.
   always @(negedge clk) begin
      if (det_clr) begin
         det_sh   <= 6'd0;
         det_len  <= 0;
         det_hits <= 0;
      end else if (bus2.a_valid === 1'b1) begin
         det_sh  <= {det_sh[4:0], bus2.a};
         det_len <= det_len + 1;
         if (det_len >= 5 && {det_sh[4:0], bus2.a} == 6'b110011) det_hits <= det_hits + 1;
      end
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: {a,a_valid,done,ready}=%b, expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs == exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int sel, input logic [3:0] e);
      if (sel == 1) q1.push_back(e);
      else q2.push_back(e);
   endtask

   // Expected stream after an accepted start: one quiet cycle, frames with gaps, done, ready.
   task automatic push_run(input int sel, input logic [5:0] pat, input int frm);
      int gap;
      gap = (sel == 1) ? 2 : 0;
      push(sel, 4'b0000);
      for (int f = 0; f < frm; f++) begin
         for (int i = 5; i >= 0; i--) push(sel, {pat[i], 3'b100});
`ifdef SEQ_GEN_PARITY_EN
         push(sel, {^pat, 3'b100});
`endif
         if (f < frm - 1) begin
            for (int g = 0; g < gap; g++) push(sel, 4'b0000);
         end
      end
      push(sel, 4'b0010);
      push(sel, 4'b0001);
   endtask

   // Compare one cycle at the falling edge, then move to just after the next rising edge.
   task automatic tick_check();
      logic [3:0] e;
      @(negedge clk);
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check({cur_tag, "/dut1"}, {bus1.a, bus1.a_valid, bus1.done, bus1.ready}, e);
      end
      if (q2.size() > 0) begin
         e = q2.pop_front();
         check({cur_tag, "/dut2"}, {bus2.a, bus2.a_valid, bus2.done, bus2.ready}, e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int left);
      int guard;
      guard = 0;
      while ((q1.size() + q2.size() > left) && guard < 3000) begin
         tick_check();
         guard++;
      end
      if (guard >= 3000) begin
         n_total++;
         n_fail++;
         $error("FAIL %s timeout: %0d entries pending, expected %0d", cur_tag, q1.size() + q2.size(), left);
      end
   endtask

   task automatic do_start(input int sel, input logic [5:0] pat, input logic [3:0] frm, input bit push_idle);
      if (sel == 1) begin
         bus1.start = 1'b1; bus1.pattern = pat; bus1.frames = frm;
      end else begin
         bus2.start = 1'b1; bus2.pattern = pat; bus2.frames = frm;
      end
      if (push_idle) push(sel, 4'b0001);
      tick_check();
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      push_run(sel, pat, int'(frm));
   endtask

   initial begin
      det_clr = 1'b1;
      rst_n   = 1'b0;
      bus1.start = 1'b0; bus1.pattern = 6'd0; bus1.frames = 4'd0; bus1.abort = 1'b0;
      bus2.start = 1'b0; bus2.pattern = 6'd0; bus2.frames = 4'd0; bus2.abort = 1'b0;

      cur_tag = "reset";
      @(negedge clk);
      check("reset/dut1", {bus1.a, bus1.a_valid, bus1.done, bus1.ready}, 4'b0001);
      check("reset/dut2", {bus2.a, bus2.a_valid, bus2.done, bus2.ready}, 4'b0001);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      cur_tag = "single";
      do_start(1, DEFAULT_PATTERN, 4'd1, 1'b1);
      drain(0);

      cur_tag = "gap3";
      do_start(1, 6'b110011, 4'd3, 1'b1);
      drain(0);

      cur_tag = "b2b";
      do_start(1, 6'b101101, 4'd2, 1'b1);
      drain(1);
      do_start(1, 6'b011010, 4'd1, 1'b0);
      drain(0);

      cur_tag = "loopback";
      det_clr = 1'b0;
      do_start(2, 6'b110011, 4'd2, 1'b1);
      drain(0);
      check_int("loopback_hits", det_hits, 2);
      det_clr = 1'b1;

      cur_tag = "abort";
      do_start(1, DEFAULT_PATTERN, 4'd2, 1'b1);
      tick_check();
      bus1.start = 1'b1; bus1.pattern = 6'b000000; bus1.frames = 4'd5;
      tick_check();
      bus1.start = 1'b0;
      tick_check();
      bus1.abort = 1'b1;
      tick_check();
      bus1.abort = 1'b0;
      q1.delete();
      for (int i = 0; i < 5; i++) push(1, 4'b0001);
      drain(0);

      cur_tag = "frames0";
      bus1.start = 1'b1; bus1.pattern = 6'b110011; bus1.frames = 4'd0;
      push(1, 4'b0001);
      tick_check();
      bus1.start = 1'b0;
      for (int i = 0; i < 3; i++) push(1, 4'b0001);
      drain(0);

      cur_tag = "abort_idle";
      bus1.abort = 1'b1; bus1.start = 1'b1; bus1.frames = 4'd1;
      push(1, 4'b0001);
      tick_check();
      bus1.abort = 1'b0; bus1.start = 1'b0;
      for (int i = 0; i < 3; i++) push(1, 4'b0001);
      drain(0);

      cur_tag = "reset_mid";
      do_start(1, 6'b110011, 4'd2, 1'b1);
      tick_check();
      tick_check();
      tick_check();
      q1.delete();
      #2 rst_n = 1'b0;
      #1;
      check("reset_mid/dut1", {bus1.a, bus1.a_valid, bus1.done, bus1.ready}, 4'b0001);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      push(1, 4'b0001);
      push(1, 4'b0001);
      drain(0);

      cur_tag = "max_frames";
      do_start(1, 6'b100001, 4'd15, 1'b1);
      drain(0);

      cur_tag = "pattern_110010";
      do_start(1, 6'b110010, 4'd1, 1'b1);
      drain(0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
